core_bus_arbiter: RTL
=====================

Name: core_bus_arbiter

Overview:
- Two-master to one-slave Avalon-MM arbiter.
- Merges the core's instruction bus and data bus onto a single shared memory port. This is used in configurations with one on-chip RAM or one external bus.
- Provides per-cycle grant, a command lock while the slave stalls, and fixed-latency read-return routing back to the issuing master.
- Sits between veriRISCV core (or the I-cache's memory side) and the memory/fabric.

Parameters:
- READ_LATENCY, 1: cycles from an accepted read command to its readdata/readdatavalid at mem_avalon_resp; legal range 1..4.

Ports:
- clk  input  1  core clock
- rst  input  1  reset
- ibus_avalon_req  input  avalon_req_t  instruction master command (read, write, address, writedata, byte_enable)
- ibus_avalon_resp  output  avalon_resp_t  instruction master response (waitrequest, readdata, readdatavalid)
- dbus_avalon_req  input  avalon_req_t  data master command
- dbus_avalon_resp  output  avalon_resp_t  data master response
- mem_avalon_req  output  avalon_req_t  shared slave command
- mem_avalon_resp  input  avalon_resp_t  shared slave response
- arb_grant_dbus  output  1  current-cycle grant owner (0=ibus, 1=dbus), debug/perf

Clock and reset:
- Single clock clk.
- Reset rst is asynchronous and active-high.

Behaviour:
- Request active: a master is active when read|write is set. Read and write set together is illegal; the arbiter treats it as a read.
- Lock FSM states: ARB_FREE, ARB_LOCK_I, ARB_LOCK_D. Reset state is ARB_FREE.
  - ARB_FREE: grant is combinational.
    - Only one master active: that master wins.
    - Both active: round-robin. The master not in last_grant wins.
    - Neither active: mem_avalon_req is all-zero, and arb_grant_dbus holds last_grant.
  - Granted command active and mem waitrequest=1: next state is ARB_LOCK_I or ARB_LOCK_D according to the granted master.
  - ARB_LOCK_x: grant is forced to x. The master must hold its command (Avalon rule). Return to ARB_FREE in the cycle after mem waitrequest=0.
  - A lock is never broken by the other master's request.
- last_grant register:
  - Resets to dbus, so the first tie goes to ibus.
  - Updated on every accepted command (active & ~mem waitrequest) to the granted master.
- Command path: mem_avalon_req = granted master's req. This path is purely combinational, with zero added latency.
- Waitrequest to masters:
  - Granted master: mem waitrequest.
  - Non-granted master: waitrequest=1 whenever it is active.
  - Non-granted master: waitrequest=0 when idle.
- Read-return pipe: shift register of depth READ_LATENCY, entries {valid, owner}.
  - Push {1, grant} when a read is accepted; push {0, x} otherwise.
  - At the pipe output, mem readdatavalid is routed to the owner. The other master sees readdatavalid=0.
  - readdata is broadcast to both masters.
  - A mem readdatavalid with no valid pipe entry is dropped. A sim-only assertion fires in that case.
- Back-to-back: grant may switch every cycle, with reads from alternating masters in consecutive cycles. Full throughput is one command per cycle when the slave does not stall.
- Writes produce no return traffic and push an invalid pipe entry.
- Reset values:
  - FSM=ARB_FREE, last_grant=dbus.
  - Pipe entries all invalid.
  - Both resp.readdatavalid=0.
- Reset mid-operation: asserted rst immediately clears the lock and the pipe. In-flight read returns are discarded and no readdatavalid reaches either master. Outputs follow the combinational rules with reset state.

Optional Feature:
- Macro: ARB_DBUS_PRIORITY_EN.
  - Defined: fixed priority. dbus wins every tie in ARB_FREE; last_grant is still maintained but unused for arbitration. Locking behaviour is unchanged.
  - Undefined: round-robin as above.

Test Plan:
- Single master: ibus read addr 0x100, slave waitrequest=0, READ_LATENCY=1 -> mem address=0x100 in the same cycle. Next cycle ibus readdatavalid=1 with slave data 0xDEADBEEF; dbus readdatavalid=0.
- Tie after reset: both issue reads (ibus 0x0, dbus 0x2000) for 4 cycles, no stall -> grant sequence I,D,I,D. Each master receives 2 readdatavalid pulses, at the cycles matching its accepted reads.
- Lock: dbus write 0x2004 with slave waitrequest=1 for 3 cycles while ibus requests -> mem_req stays the dbus write for all 4 cycles and ibus waitrequest=1 throughout. ibus is granted the cycle after dbus is accepted.
- Latency routing with READ_LATENCY=3: alternating I/D reads for 6 cycles -> readdatavalid delivered to owners in order I,D,I,D,I,D, each 3 cycles after its acceptance.
- Reset mid-read: rst asserted one cycle after an accepted read with READ_LATENCY=2 -> no readdatavalid to either master; FSM is ARB_FREE; the next tie goes to ibus.
- With ARB_DBUS_PRIORITY_EN: both masters continuously request for 4 cycles, no stall -> dbus granted all 4 cycles and ibus waitrequest=1 throughout.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges ibus and dbus Avalon-MM masters onto one slave port.
// Optional: define ARB_DBUS_PRIORITY_EN to give dbus fixed priority on ties.
package core_bus_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
  } avalon_resp_t;

endpackage

module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  ibus_avalon_req,
  output avalon_resp_t ibus_avalon_resp,
  input  avalon_req_t  dbus_avalon_req,
  output avalon_resp_t dbus_avalon_resp,
  output avalon_req_t  mem_avalon_req,
  input  avalon_resp_t mem_avalon_resp,
  output logic         arb_grant_dbus
);

  typedef enum logic [1:0] {
    ARB_FREE,
    ARB_LOCK_I,
    ARB_LOCK_D
  } arb_state_t;

  arb_state_t state;
  arb_state_t state_nxt;

  logic last_grant;
  logic tie_grant;
  logic grant;
  logic i_act;
  logic d_act;
  logic g_act;
  logic accept;
  logic rd_accept;
  logic mem_wait;
  logic pipe_out_vld;
  logic pipe_out_own;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_own;

  avalon_req_t g_req;

  assign i_act    = ibus_avalon_req.read | ibus_avalon_req.write;
  assign d_act    = dbus_avalon_req.read | dbus_avalon_req.write;
  assign mem_wait = mem_avalon_resp.waitrequest;

`ifdef ARB_DBUS_PRIORITY_EN
  assign tie_grant = 1'b1;
`else
  assign tie_grant = ~last_grant;
`endif

  // Grant owner: forced while locked, otherwise picked from active masters.
  always_comb begin
    grant = last_grant;
    unique case (state)
      ARB_LOCK_I: grant = 1'b0;
      ARB_LOCK_D: grant = 1'b1;
      default: begin
        if (i_act && d_act) begin
          grant = tie_grant;
        end else if (d_act) begin
          grant = 1'b1;
        end else if (i_act) begin
          grant = 1'b0;
        end
      end
    endcase
  end

  assign g_req     = grant ? dbus_avalon_req : ibus_avalon_req;
  assign g_act     = grant ? d_act : i_act;
  assign accept    = g_act & ~mem_wait;
  assign rd_accept = accept & g_req.read;

  assign arb_grant_dbus = grant;

  // Lock FSM next state: hold the owner while the slave stalls its command.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_FREE: begin
        if (g_act && mem_wait) begin
          state_nxt = grant ? ARB_LOCK_D : ARB_LOCK_I;
        end
      end
      ARB_LOCK_I, ARB_LOCK_D: begin
        if (!mem_wait) begin
          state_nxt = ARB_FREE;
        end
      end
      default: state_nxt = ARB_FREE;
    endcase
  end

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_FREE;
    end else begin
      state <= state_nxt;
    end
  end

  // Remember who won the last accepted command for round-robin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

  // Read-return pipe: one slot per cycle, tagged with the issuing master.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_own <= '0;
    end else begin
      pipe_vld[0] <= rd_accept;
      pipe_own[0] <= grant;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

  assign pipe_out_vld = pipe_vld[READ_LATENCY-1];
  assign pipe_out_own = pipe_own[READ_LATENCY-1];

  // Shared command: granted master's request, zero when it is idle.
  // A read+write command is issued as a plain read.
  always_comb begin
    mem_avalon_req = '0;
    if (g_act) begin
      mem_avalon_req       = g_req;
      mem_avalon_req.write = g_req.write & ~g_req.read;
    end
  end

  // Master responses: stall the loser, route readdatavalid to its owner.
  always_comb begin
    ibus_avalon_resp = '0;
    dbus_avalon_resp = '0;
    ibus_avalon_resp.readdata = mem_avalon_resp.readdata;
    dbus_avalon_resp.readdata = mem_avalon_resp.readdata;
    ibus_avalon_resp.waitrequest = grant ? i_act : mem_wait;
    dbus_avalon_resp.waitrequest = grant ? mem_wait : d_act;
    ibus_avalon_resp.readdatavalid =
      mem_avalon_resp.readdatavalid & pipe_out_vld & ~pipe_out_own;
    dbus_avalon_resp.readdatavalid =
      mem_avalon_resp.readdatavalid & pipe_out_vld & pipe_out_own;
  end

`ifndef SYNTHESIS
  // A slave return with no read outstanding is dropped; flag it in sim.
  a_orphan_rdv : assert property (
    @(posedge clk) disable iff (rst)
    mem_avalon_resp.readdatavalid |-> pipe_out_vld
  ) else $error("orphan readdatavalid from slave");
`endif

endmodule
